// File: rtl/line_dir_arbiter.sv
// line_dir_arbiter: hands the shared device data line to PHY or Memory, one owner at a time,
// with a registered no-driver turnaround gap. Define ARB_HOLD_TIMEOUT_EN to force release after MAX_HOLD cycles.
module line_dir_arbiter #(
  parameter int TURN_CYCLES = 2,
  parameter int MAX_HOLD    = 64,
  parameter int CNT_W       = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic phy_req_i,
  input  logic phy_done_i,
  input  logic mem_req_i,
  input  logic mem_done_i,
  output logic phy_gnt_o,
  output logic mem_gnt_o,
  output logic tx_oe,
  output logic mem_oe_o,
  output logic busy_o,
  output logic timeout_o
);

  typedef enum logic [1:0] {IDLE, GNT_PHY, GNT_MEM, TURN} state_t;

  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // With no turnaround the release edge drops straight back to IDLE.
  localparam state_t           REL_STATE = (TURN_CYCLES == 0) ? IDLE : TURN;
  localparam logic             REL_BUSY  = (TURN_CYCLES != 0);

  if (TURN_CYCLES < 0 || MAX_HOLD < 1 || CNT_W < 1 ||
      TURN_CYCLES >= (1 << CNT_W) || MAX_HOLD > (1 << CNT_W)) begin : g_bad_cfg
    $error("line_dir_arbiter: CNT_W too narrow for TURN_CYCLES/MAX_HOLD");
  end

  state_t           state;
  logic [CNT_W-1:0] turn_cnt;
  logic             last_mem;  // Memory owned the line last, so PHY wins the next tie
  logic             hold_expire;
  logic             phy_release;
  logic             mem_release;
  logic             phy_forced;
  logic             mem_forced;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] hold_cnt;

  // Cleared on every IDLE edge (which includes the granting edge), counts grant cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if ((state == GNT_PHY || state == GNT_MEM) && hold_cnt != '1) begin
      hold_cnt <= hold_cnt + CNT_ONE;
    end
  end

  assign hold_expire = (hold_cnt == HOLD_LAST);
`else
  assign hold_expire = 1'b0;
`endif

  assign phy_release = phy_done_i | ~phy_req_i | hold_expire;
  assign mem_release = mem_done_i | ~mem_req_i | hold_expire;
  assign phy_forced  = hold_expire & phy_req_i & ~phy_done_i;
  assign mem_forced  = hold_expire & mem_req_i & ~mem_done_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      turn_cnt  <= '0;
      last_mem  <= 1'b1;
      phy_gnt_o <= 1'b0;
      mem_gnt_o <= 1'b0;
      busy_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (phy_req_i && (!mem_req_i || last_mem)) begin
            state     <= GNT_PHY;
            phy_gnt_o <= 1'b1;
            busy_o    <= 1'b1;
          end else if (mem_req_i) begin
            state     <= GNT_MEM;
            mem_gnt_o <= 1'b1;
            busy_o    <= 1'b1;
          end
        end
        GNT_PHY: begin
          if (phy_release) begin
            state     <= REL_STATE;
            phy_gnt_o <= 1'b0;
            busy_o    <= REL_BUSY;
            last_mem  <= 1'b0;
            turn_cnt  <= TURN_LOAD;
            timeout_o <= phy_forced;
          end
        end
        GNT_MEM: begin
          if (mem_release) begin
            state     <= REL_STATE;
            mem_gnt_o <= 1'b0;
            busy_o    <= REL_BUSY;
            last_mem  <= 1'b1;
            turn_cnt  <= TURN_LOAD;
            timeout_o <= mem_forced;
          end
        end
        TURN: begin
          if (turn_cnt <= CNT_ONE) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            turn_cnt <= '0;
          end else begin
            turn_cnt <= turn_cnt - CNT_ONE;
          end
        end
        default: begin
          state     <= IDLE;
          phy_gnt_o <= 1'b0;
          mem_gnt_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

  assign tx_oe    = phy_gnt_o;
  assign mem_oe_o = mem_gnt_o;

endmodule

// File: tb/tb_line_dir_arbiter.sv
// Scoreboard bench for line_dir_arbiter: directed vectors push expected outputs, a negedge monitor
// pops and compares them, and a second monitor watches contention and turnaround gaps throughout.
module tb_line_dir_arbiter;

  localparam int TURN = 2;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst;
  logic phy_req, phy_done, mem_req, mem_done;
  logic phy_gnt, mem_gnt, tx_oe, mem_oe, busy, timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  line_dir_arbiter #(.TURN_CYCLES(TURN), .MAX_HOLD(HOLD), .CNT_W(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .phy_req_i (phy_req),
    .phy_done_i(phy_done),
    .mem_req_i (mem_req),
    .mem_done_i(mem_done),
    .phy_gnt_o (phy_gnt),
    .mem_gnt_o (mem_gnt),
    .tx_oe     (tx_oe),
    .mem_oe_o  (mem_oe),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  // Expected vector layout: {phy_gnt, mem_gnt, tx_oe, mem_oe, busy, timeout}
  function automatic logic [5:0] mk(input bit p, input bit m, input bit b, input bit t);
    return {p, m, p, m, b, t};
  endfunction

  function automatic logic [5:0] outs();
    return {phy_gnt, mem_gnt, tx_oe, mem_oe, busy, timeout};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs {phy_req, phy_done, mem_req, mem_done} are applied, one edge runs, expectation is queued.
  task automatic cyc(input logic [3:0] in, input logic [5:0] exp, input string name);
    {phy_req, phy_done, mem_req, mem_done} = in;
    @(posedge clk);
    sb_q.push_back('{exp, name});
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("async_reset", outs(), 6'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, outs(), e.exp);
    end
  end

  // Contention and turnaround monitor
  int       low_run    = 0;
  bit       seen_owner = 1'b0;
  bit [1:0] prev_own   = 2'b00;
  always @(negedge clk) begin
    if (rst) begin
      low_run    = 0;
      seen_owner = 1'b0;
      prev_own   = 2'b00;
    end else begin
      check("no_contention", {5'b0, tx_oe & mem_oe}, 6'b0);
      if (tx_oe | mem_oe) begin
        if (seen_owner && {tx_oe, mem_oe} != prev_own)
          check("turn_gap", {5'b0, (low_run < TURN + 1)}, 6'b0);
        seen_owner = 1'b1;
        low_run    = 0;
      end else begin
        low_run++;
      end
      prev_own = {tx_oe, mem_oe};
    end
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1'b1;
    {phy_req, phy_done, mem_req, mem_done} = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", outs(), 6'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) cyc(4'b0000, mk(0, 0, 0, 0), "idle_no_req");

    // PHY alone: grant, hold, release, turnaround
    cyc(4'b1000, mk(1, 0, 1, 0), "phy_grant");
    repeat (3) cyc(4'b1000, mk(1, 0, 1, 0), "phy_hold");
    cyc(4'b1100, mk(0, 0, 1, 0), "phy_done_release");
    cyc(4'b0000, mk(0, 0, 1, 0), "phy_turn");
    cyc(4'b0000, mk(0, 0, 0, 0), "phy_turn_end");
    cyc(4'b0000, mk(0, 0, 0, 0), "idle_after_turn");

    // Tie after reset: PHY first, then Memory, then round robin back to PHY
    do_reset();
    cyc(4'b1010, mk(1, 0, 1, 0), "tie_phy_first");
    cyc(4'b1011, mk(1, 0, 1, 0), "mem_done_ignored");
    cyc(4'b1010, mk(1, 0, 1, 0), "tie_phy_hold");
    cyc(4'b1110, mk(0, 0, 1, 0), "tie_phy_release");
    cyc(4'b0010, mk(0, 0, 1, 0), "tie_turn");
    cyc(4'b0010, mk(0, 0, 0, 0), "tie_idle");
    cyc(4'b0010, mk(0, 1, 1, 0), "tie_mem_grant");
    cyc(4'b1010, mk(0, 1, 1, 0), "phy_req_ignored");
    cyc(4'b1011, mk(0, 0, 1, 0), "mem_done_release");
    cyc(4'b1010, mk(0, 0, 1, 0), "rr_turn");
    cyc(4'b1010, mk(0, 0, 0, 0), "rr_idle");
    cyc(4'b1010, mk(1, 0, 1, 0), "rr_phy_wins");
    cyc(4'b0010, mk(0, 0, 1, 0), "phy_abandon");
    cyc(4'b0010, mk(0, 0, 1, 0), "abandon_turn");
    cyc(4'b0010, mk(0, 0, 0, 0), "abandon_idle");
    cyc(4'b0010, mk(0, 1, 1, 0), "mem_grant");

    // Reset mid GNT_MEM with both requests pending: PHY wins afterwards
    {phy_req, phy_done, mem_req, mem_done} = 4'b1010;
    do_reset();
    cyc(4'b1010, mk(1, 0, 1, 0), "phy_first_after_reset");
    cyc(4'b1100, mk(0, 0, 1, 0), "post_reset_release");
    cyc(4'b0000, mk(0, 0, 1, 0), "post_reset_turn");
    cyc(4'b0000, mk(0, 0, 0, 0), "post_reset_idle");

    // Same requester re-requesting still passes through TURN and IDLE
    cyc(4'b1000, mk(1, 0, 1, 0), "rereq_grant");
    cyc(4'b1100, mk(0, 0, 1, 0), "rereq_release");
    cyc(4'b1000, mk(0, 0, 1, 0), "rereq_turn");
    cyc(4'b1000, mk(0, 0, 0, 0), "rereq_idle");
    cyc(4'b1000, mk(1, 0, 1, 0), "rereq_regrant");

`ifdef ARB_HOLD_TIMEOUT_EN
    for (int i = 1; i < HOLD; i++) cyc(4'b1010, mk(1, 0, 1, 0), "hold_before_timeout");
    cyc(4'b1010, mk(0, 0, 1, 1), "hold_timeout");
`else
    for (int i = 0; i < 100; i++) cyc(4'b1010, mk(1, 0, 1, 0), "hold_no_timeout");
    cyc(4'b1110, mk(0, 0, 1, 0), "hold_done_release");
`endif
    cyc(4'b0010, mk(0, 0, 1, 0), "hold_turn");
    cyc(4'b0010, mk(0, 0, 0, 0), "hold_idle");
    cyc(4'b0010, mk(0, 1, 1, 0), "mem_after_hold");
    cyc(4'b0011, mk(0, 0, 1, 0), "mem_release_final");
    cyc(4'b0000, mk(0, 0, 1, 0), "final_turn");
    cyc(4'b0000, mk(0, 0, 0, 0), "final_idle");

    // Random traffic: only the contention/turnaround monitor judges this phase
    for (int i = 0; i < 10000; i++) begin
      phy_req  = ($urandom_range(0, 3) != 0);
      phy_done = ($urandom_range(0, 7) == 0);
      mem_req  = ($urandom_range(0, 3) != 0);
      mem_done = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      #1;
    end

    {phy_req, phy_done, mem_req, mem_done} = 4'b0000;
    do_reset();
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
